// File: rtl/tm1637_pkg.sv
// Shared constants and encodings for the TM1637 frame sequencer.
// The step enum encoding is what debug_step_id shows.
package tm1637_pkg;

    localparam logic [7:0] CMD_DATA_WRITE = 8'h40;
    localparam logic [7:0] CMD_ADDR0      = 8'hC0;
    localparam logic [7:0] CMD_DISP       = 8'h80;

    typedef enum logic [6:0] {
        PWRUP    = 7'd0,
        IDLE     = 7'd1,
        C1_START = 7'd2,
        C1_BYTE  = 7'd3,
        C1_STOP  = 7'd4,
        C2_START = 7'd5,
        C2_ADDR  = 7'd6,
        C2_DATA  = 7'd7,
        C2_STOP  = 7'd8,
        C3_START = 7'd9,
        C3_BYTE  = 7'd10,
        C3_STOP  = 7'd11
    } step_e;

    typedef enum logic [1:0] {
        OP_START = 2'd0,
        OP_BYTE  = 2'd1,
        OP_STOP  = 2'd2
    } op_e;

endpackage

// File: rtl/tm1637_bus_phy.sv
// Executes one bus op (start, byte + ACK, stop) on the TM1637 two-wire bus,
// advancing one bus phase per tick.
module tm1637_bus_phy
    import tm1637_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       go,
    input  op_e        op,
    input  logic [7:0] data_byte,
    input  logic       dio_s,
    output logic       done,
    output logic       nack,
    output logic       tm1637_clk,
    output logic       tm1637_dio_oe
);

    op_e        op_r;
    logic [7:0] byte_r;
    logic [4:0] idx;
    logic       active;

    function automatic logic [4:0] last_idx(input op_e o);
        case (o)
            OP_START: last_idx = 5'd1;
            OP_BYTE:  last_idx = 5'd17;
            default:  last_idx = 5'd2;
        endcase
    endfunction

    // Returns {clk, dio_oe} for phase i of op o; byte bits go out LSB first.
    function automatic logic [1:0] bus_level(input op_e o, input logic [4:0] i, input logic [7:0] b);
        logic [3:0] bit_i;
        bit_i     = i[4:1];
        bus_level = 2'b10;
        case (o)
            OP_START: bus_level = (i == 5'd0) ? 2'b11 : 2'b01;
            OP_BYTE:  bus_level = {i[0], (bit_i < 4'd8) ? ~b[bit_i[2:0]] : 1'b0};
            OP_STOP: begin
                case (i)
                    5'd0:    bus_level = 2'b01;
                    5'd1:    bus_level = 2'b11;
                    default: bus_level = 2'b10;
                endcase
            end
            default: bus_level = 2'b10;
        endcase
    endfunction

    assign done = active && tick && (idx == last_idx(op_r));
    assign nack = done && (op_r == OP_BYTE) && dio_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r          <= OP_START;
            byte_r        <= '0;
            idx           <= '0;
            active        <= 1'b0;
            tm1637_clk    <= 1'b1;
            tm1637_dio_oe <= 1'b0;
        end else if (go) begin
            // go arrives on the same cycle as the previous op's done, so the
            // new op's first phase starts without a gap.
            op_r                        <= op;
            byte_r                      <= data_byte;
            idx                         <= '0;
            active                      <= 1'b1;
            {tm1637_clk, tm1637_dio_oe} <= bus_level(op, 5'd0, data_byte);
        end else if (active && tick) begin
            if (idx == last_idx(op_r)) begin
                active <= 1'b0;
            end else begin
                idx                         <= idx + 5'd1;
                {tm1637_clk, tm1637_dio_oe} <= bus_level(op_r, idx + 5'd1, byte_r);
            end
        end
    end

endmodule

// File: rtl/tm1637_frame_seq.sv
// Frame-level TM1637 controller: power-up delay, frame handshake, and the
// three-command write sequence driven through tm1637_bus_phy.
module tm1637_frame_seq
    import tm1637_pkg::*;
#(
    parameter int unsigned CLK_DIV        = 250,
    parameter int unsigned POWERUP_CYCLES = 50000,
    parameter int unsigned NUM_DIGITS     = 4
) (
    input  logic                    clk_50M,
    input  logic                    rst_n,
    input  logic                    frame_valid,
    output logic                    frame_ready,
    input  logic [8*NUM_DIGITS-1:0] frame_digits,
    input  logic [2:0]              frame_bright,
    input  logic                    frame_on,
    output logic                    busy,
    output logic                    ack_err,
    output logic                    tm1637_clk,
    output logic                    tm1637_dio_oe,
    input  logic                    tm1637_dio_i,
    output logic                    tm1637_vcc,
    output logic [6:0]              debug_step_id
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned PWR_W = $clog2(POWERUP_CYCLES + 1);

    step_e                   state, next_state;
    logic [DIV_W-1:0]        div_cnt;
    logic [PWR_W-1:0]        pwr_cnt;
    logic [8*NUM_DIGITS-1:0] digits_r;
    logic [7:0]              c3_r;
    logic [2:0]              digit_idx;
    logic [1:0]              dio_sync;
    logic                    tick, accept, go, done, nack, digit_inc;
    op_e                     op;
    logic [7:0]              data_byte, digit_next;

    assign tick          = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign debug_step_id = state;

    always_comb begin
        digit_next = digits_r[7:0];
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (k == 32'(digit_idx) + 32'd1) digit_next = digits_r[8*k +: 8];
        end
    end

    always_comb begin
        next_state = state;
        go         = 1'b0;
        op         = OP_START;
        data_byte  = '0;
        accept     = 1'b0;
        digit_inc  = 1'b0;
        case (state)
            PWRUP: if (pwr_cnt == PWR_W'(POWERUP_CYCLES)) next_state = IDLE;
            IDLE: if (frame_valid) begin
                accept = 1'b1;
                go = 1'b1; op = OP_START; next_state = C1_START;
            end
            C1_START: if (done) begin
                go = 1'b1; op = OP_BYTE; data_byte = CMD_DATA_WRITE; next_state = C1_BYTE;
            end
            C1_BYTE: if (done) begin
                go = 1'b1; op = OP_STOP; next_state = C1_STOP;
            end
            C1_STOP: if (done) begin
                go = 1'b1; op = OP_START; next_state = C2_START;
            end
            C2_START: if (done) begin
                go = 1'b1; op = OP_BYTE; data_byte = CMD_ADDR0; next_state = C2_ADDR;
            end
            C2_ADDR: if (done) begin
                go = 1'b1; op = OP_BYTE; data_byte = digits_r[7:0]; next_state = C2_DATA;
            end
            C2_DATA: if (done) begin
                go = 1'b1;
                if (digit_idx == 3'(NUM_DIGITS - 1)) begin
                    op = OP_STOP; next_state = C2_STOP;
                end else begin
                    op = OP_BYTE; data_byte = digit_next; digit_inc = 1'b1;
                end
            end
            C2_STOP: if (done) begin
                go = 1'b1; op = OP_START; next_state = C3_START;
            end
            C3_START: if (done) begin
                go = 1'b1; op = OP_BYTE; data_byte = c3_r; next_state = C3_BYTE;
            end
            C3_BYTE: if (done) begin
                go = 1'b1; op = OP_STOP; next_state = C3_STOP;
            end
            C3_STOP: if (done) next_state = IDLE;
            default: next_state = PWRUP;
        endcase
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state       <= PWRUP;
            frame_ready <= 1'b0;
            busy        <= 1'b0;
            ack_err     <= 1'b0;
            tm1637_vcc  <= 1'b0;
            div_cnt     <= '0;
            pwr_cnt     <= '0;
            digits_r    <= '0;
            c3_r        <= '0;
            digit_idx   <= '0;
            dio_sync    <= '1;
        end else begin
            state       <= next_state;
            frame_ready <= (next_state == IDLE);
            busy        <= (next_state != IDLE) && (next_state != PWRUP);
            tm1637_vcc  <= 1'b1;
            dio_sync    <= {dio_sync[0], tm1637_dio_i};
            div_cnt     <= (accept || tick) ? '0 : div_cnt + DIV_W'(1);
            if (state == PWRUP && next_state == PWRUP) pwr_cnt <= pwr_cnt + PWR_W'(1);
            if (accept) begin
                ack_err   <= 1'b0;
                digits_r  <= frame_digits;
                c3_r      <= CMD_DISP | {4'b0000, frame_on, frame_bright};
                digit_idx <= '0;
            end else begin
                if (nack) ack_err <= 1'b1;
                if (digit_inc) digit_idx <= digit_idx + 3'd1;
            end
        end
    end

    tm1637_bus_phy u_phy (
        .clk           (clk_50M),
        .rst_n         (rst_n),
        .tick          (tick),
        .go            (go),
        .op            (op),
        .data_byte     (data_byte),
        .dio_s         (dio_sync[1]),
        .done          (done),
        .nack          (nack),
        .tm1637_clk    (tm1637_clk),
        .tm1637_dio_oe (tm1637_dio_oe)
    );

endmodule
